// File: rtl/dlx_fetch_stage.sv
// rtl/dlx_fetch_stage.sv - DLX instruction fetch stage with IF/ID register (optional FETCH_PERF_CNT_EN counters)
module dlx_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0015
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        beqz,
    input  logic        bnez,
    input  logic        jump,
    input  logic        jumpReg,
    input  logic [25:0] value,
    input  logic [15:0] imm16,
    input  logic [31:0] rs1_data,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] id_pc4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] squash_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic        taken
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] disc_addr_q, disc_addr_d;

    logic        br_taken;
    logic        taken_w;
    logic [31:0] target;

    assign br_taken = (beqz && (rs1_data == 32'd0)) || (bnez && (rs1_data != 32'd0));
    assign taken_w  = !stall && (jump || br_taken);

    // Redirect target for the instruction currently sitting in ID
    always_comb begin
        target = id_pc4_q + {{16{imm16[15]}}, imm16};
        if (jump) begin
            if (jumpReg) begin
                target = rs1_data;
            end else begin
                target = id_pc4_q + {{6{value[25]}}, value};
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a miss parks in WAIT, a redirect during a miss must drain the stale request
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH, S_WAIT: begin
                if (imem_ready) begin
                    state_d = S_FETCH;
                end else if (taken_w) begin
                    state_d = S_DISCARD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DISCARD: begin
                if (imem_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // FSM outputs: the stale address stays on the bus while draining a redirected miss
    always_comb begin
        imem_req  = !reset;
        imem_addr = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
        taken     = taken_w;
    end

    // Datapath next state for PC, IF/ID register and the drained-request address
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        id_pc4_d    = id_pc4_q;
        disc_addr_d = disc_addr_q;
        if (state_q == S_DISCARD) begin
            if (!stall) begin
                instr_d = NOP_INSTR;
            end
            if (taken_w) begin
                pc_d = target;
            end
        end else if (imem_ready) begin
            if (taken_w) begin
                pc_d    = target;
                instr_d = NOP_INSTR;
            end else if (!stall) begin
                instr_d  = imem_data;
                id_pc4_d = pc_q + 32'd4;
                pc_d     = pc_q + 32'd4;
            end
        end else begin
            if (!stall) begin
                instr_d = NOP_INSTR;
            end
            if (taken_w) begin
                pc_d        = target;
                disc_addr_d = pc_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            id_pc4_q    <= 32'd0;
            disc_addr_q <= RESET_PC;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            id_pc4_q    <= id_pc4_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    assign instr  = instr_q;
    assign id_pc4 = id_pc4_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] squash_cnt_q, bubble_cnt_q;
    logic        bubble_ins;

    assign bubble_ins = !stall && (!imem_ready || (state_q == S_DISCARD));

    // Saturating redirect and bubble counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_cnt_q <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (taken_w && (squash_cnt_q != 32'hFFFF_FFFF)) begin
                squash_cnt_q <= squash_cnt_q + 32'd1;
            end
            if (bubble_ins && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign squash_cnt = squash_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_dlx_fetch_stage.sv
// tb/tb_dlx_fetch_stage.sv - self-checking bench for dlx_fetch_stage
module tb_dlx_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0015;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, beqz, bnez, jump, jumpReg;
    logic [25:0] value;
    logic [15:0] imm16;
    logic [31:0] rs1_data;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] instr, id_pc4;
    logic        taken;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] squash_cnt, bubble_cnt;
`endif

    always #5 clk = ~clk;

    dlx_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .beqz(beqz), .bnez(bnez),
        .jump(jump), .jumpReg(jumpReg), .value(value), .imm16(imm16),
        .rs1_data(rs1_data), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_data(imem_data), .instr(instr),
        .id_pc4(id_pc4),
`ifdef FETCH_PERF_CNT_EN
        .squash_cnt(squash_cnt), .bubble_cnt(bubble_cnt),
`endif
        .taken(taken)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: committed PC, IF/ID contents, and at most one outstanding request
    logic [31:0] m_pc, m_instr, m_pc4, m_paddr;
    logic        m_pend, m_drop;
    logic [31:0] m_sq, m_bb;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A00, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 0; beqz = 0; bnez = 0; jump = 0; jumpReg = 0;
        value = '0; imm16 = '0; rs1_data = '0; imem_ready = 1;
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_instr = NOP; m_pc4 = 0; m_paddr = 0;
        m_pend = 0; m_drop = 0; m_sq = 0; m_bb = 0;
    endtask

    task automatic check_regs();
        chk("instr", instr, m_instr);
        chk("id_pc4", id_pc4, m_pc4);
`ifdef FETCH_PERF_CNT_EN
        chk("squash_cnt", squash_cnt, m_sq);
        chk("bubble_cnt", bubble_cnt, m_bb);
`endif
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check registers after the edge
    task automatic step();
        logic        tk;
        logic [31:0] tg, cur;
        @(negedge clk);
        imem_data = mem_word(imem_addr);
        cur = m_pend ? m_paddr : m_pc;
        tk  = !stall && (jump || (beqz && rs1_data == 0) || (bnez && rs1_data != 0));
        if (jump && jumpReg) tg = rs1_data;
        else if (jump)       tg = m_pc4 + {{6{value[25]}}, value};
        else                 tg = m_pc4 + {{16{imm16[15]}}, imm16};
        chk("imem_req", {31'd0, imem_req}, 32'd1);
        chk("imem_addr", imem_addr, cur);
        chk("taken", {31'd0, taken}, {31'd0, tk});
        if (tk && m_sq != 32'hFFFF_FFFF) m_sq++;
        if (!stall && (!imem_ready || m_drop) && m_bb != 32'hFFFF_FFFF) m_bb++;
        if (imem_ready) begin
            if (m_drop) begin
                if (!stall) m_instr = NOP;
                if (tk) m_pc = tg;
            end else if (tk) begin
                m_pc = tg; m_instr = NOP;
            end else if (!stall) begin
                m_instr = mem_word(cur); m_pc4 = m_pc + 4; m_pc = m_pc + 4;
            end
            m_pend = 0; m_drop = 0;
        end else begin
            if (!stall) m_instr = NOP;
            if (!m_pend) begin m_pend = 1; m_paddr = cur; end
            if (tk) begin m_pc = tg; m_drop = 1; end
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic check_reset_now();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        check_regs();
    endtask

    initial begin
        logic [31:0] r;
        idle();
        imem_data = '0;
        reset = 1;
        model_reset();
        #1;
        check_reset_now();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        // Sequential fetch: 0,4,8,C then up to id_pc4 = 0x20
        for (int i = 0; i < 8; i++) begin
            step();
            chk("seq_pc4", id_pc4, 32'(4 * (i + 1)));
            chk("seq_instr", instr, mem_word(32'(4 * i)));
        end

        // BEQZ taken back to 0x18
        beqz = 1; rs1_data = 0; imm16 = 16'hFFF8;
        step();
        chk("beqz_addr", imem_addr, 32'h18);
        chk("beqz_squash", instr, NOP);
        idle();
        step(); step();
        chk("beqz_pc4_again", id_pc4, 32'h20);
        beqz = 1; rs1_data = 5; imm16 = 16'hFFF8;
        step();
        chk("beqz_not_taken", imem_addr, 32'h24);

        // JR held by stall for two cycles
        idle();
        jump = 1; jumpReg = 1; rs1_data = 32'h1000; stall = 1;
        step(); step();
        chk("jr_stall_addr", imem_addr, 32'h24);
        stall = 0;
        step();
        chk("jr_addr", imem_addr, 32'h1000);

        // Three-cycle miss at 0x40
        rs1_data = 32'h40;
        step();
        idle();
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("miss_addr", imem_addr, 32'h40);
            chk("miss_nop", instr, NOP);
        end
        imem_ready = 1;
        step();
        chk("miss_accept", instr, mem_word(32'h40));
        chk("miss_next", imem_addr, 32'h44);

        // Jump while waiting at 0x80 to 0x200
        jump = 1; jumpReg = 1; rs1_data = 32'h80;
        step();
        idle(); imem_ready = 0;
        step();
        jump = 1; jumpReg = 1; rs1_data = 32'h200;
        step();
        chk("disc_hold", imem_addr, 32'h80);
        idle(); imem_ready = 0;
        step();
        chk("disc_hold2", imem_addr, 32'h80);
        imem_ready = 1;
        step();
        chk("disc_drop", instr, NOP);
        chk("disc_next", imem_addr, 32'h200);
        step();
        chk("disc_target_word", instr, mem_word(32'h200));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            imem_ready = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            beqz       = ($urandom_range(0, 9) == 0);
            bnez       = ($urandom_range(0, 9) == 0);
            jump       = ($urandom_range(0, 9) == 0);
            jumpReg    = $urandom_range(0, 1) == 1;
            value      = r[25:0];
            imm16      = r[31:16];
            rs1_data   = ($urandom_range(0, 2) == 0) ? 32'd0 : {$urandom} & 32'h0000_FFFC;
            step();
        end

        // Reset asserted while waiting
        idle(); imem_ready = 0;
        step();
        reset = 1;
        model_reset();
        #1;
        check_reset_now();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlx_fetch_stage.md
Name: dlx_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage DLX pipeline.
- Directly upstream of the decode/control block:
  - consumes its stall, beqz, bnez, jump, jumpReg, value and imm16 outputs;
  - drives the instr word that block decodes.
- Owns the PC, the instruction-memory request handshake, branch/jump redirect and squash (NOP bubble) insertion.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000015, bubble word written into IF/ID on squash or fetch miss.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  load-use stall from decode: hold PC and IF/ID.
- beqz  input  1  instruction in ID is BEQZ.
- bnez  input  1  instruction in ID is BNEZ.
- jump  input  1  instruction in ID is J/JAL/JR/JALR.
- jumpReg  input  1  with jump: target comes from rs1_data.
- value  input  26  J-type offset from ID instruction.
- imm16  input  16  branch offset from ID instruction.
- rs1_data  input  32  forwarded rs1 operand for branch test and JR target.
- imem_addr  output  32  fetch address.
- imem_req  output  1  fetch request.
- imem_ready  input  1  imem_data valid this cycle for the current request.
- imem_data  input  32  fetched instruction.
- instr  output  32  IF/ID instruction register.
- id_pc4  output  32  IF/ID PC+4 of instr; link value and branch base.
- taken  output  1  combinational: redirect accepted this cycle.

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, instr=NOP_INSTR, id_pc4=0, state=FETCH, imem_req=0 while reset is high.
  - First request is issued the first cycle after reset deasserts.
- Redirect conditions, evaluated on the ID instruction:
  - brTaken = (beqz & rs1_data==0) | (bnez & rs1_data!=0).
  - taken = ~stall & (jump | brTaken).
- Redirect targets:
  - Branch: id_pc4 + sext(imm16).
  - J/JAL: id_pc4 + sext(value).
  - JR/JALR: rs1_data.
  - Adds are 32-bit modulo 2^32; no alignment check (bits [1:0] pass through).
- Priority: reset > stall > taken > normal fetch.
- FSM states: FETCH, WAIT, DISCARD.
- imem_req is 1 in FETCH, WAIT and DISCARD. imem_addr = pc in FETCH/WAIT, the latched old address in DISCARD.
- FETCH, imem_ready=1:
  - stall: PC, instr and id_pc4 all hold; the returned word is dropped and refetched next cycle.
  - taken: pc<=target, instr<=NOP_INSTR (squash), stay FETCH.
  - otherwise: instr<=imem_data, id_pc4<=pc+4, pc<=pc+4.
- FETCH, imem_ready=0:
  - PC holds; go to WAIT.
  - If not stalled, instr<=NOP_INSTR (bubble).
  - If taken: pc<=target, go to DISCARD.
- WAIT: address held stable.
  - ready & ~taken & ~stall: accept as in FETCH, go to FETCH.
  - ready & stall: hold, go to FETCH.
  - ~ready: bubble as above.
  - taken with ~ready: pc<=target, go to DISCARD.
  - taken with ready: pc<=target, squash, go to FETCH.
- DISCARD:
  - Old request stays on the bus until imem_ready; the returned data is dropped; then go to FETCH at the new pc.
  - instr<=NOP_INSTR each unstalled cycle.
  - A further taken overwrites pc.
- Only one request is outstanding at a time. imem_addr never changes while imem_req=1 and ready=0.
- Reset mid-WAIT/DISCARD aborts immediately; the memory side must tolerate request withdrawal.

Optional Feature:
- FETCH_PERF_CNT_EN defined adds outputs:
  - squash_cnt[31:0]: increments on each taken.
  - bubble_cnt[31:0]: increments on each cycle NOP_INSTR is inserted because of a miss or DISCARD.
- Both counters clear on reset and saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, imem_ready=1 always, memory returns addr-tagged words:
  - imem_addr goes 0,4,8,C;
  - instr follows one cycle behind the address;
  - id_pc4 is 4,8,C.
- BEQZ in ID with rs1_data=0, imm16=16'hFFF8, id_pc4=0x20:
  - taken=1, next imem_addr=0x18, instr=32'h00000015 the next cycle.
  - Same case with rs1_data=5: no redirect.
- JR with rs1_data=0x1000 while stall=1 for 2 cycles:
  - no redirect during stall, PC and instr held;
  - on the cycle stall drops, taken=1 and imem_addr=0x1000.
- imem_ready low 3 cycles at addr 0x40:
  - imem_addr stays 0x40;
  - instr=NOP for 3 cycles;
  - then the 0x40 word is accepted and pc=0x44.
- Jump taken while waiting at 0x80 (target 0x200):
  - addr stays 0x80 until ready, then that data is discarded;
  - next request is at 0x200, and only the 0x200 word reaches instr.
- Assert reset in WAIT:
  - imem_req=0, pc=RESET_PC, instr=NOP immediately;
  - with FETCH_PERF_CNT_EN, both counters read 0.
